cp0_exc_unit: RTL and testbench

//  Coprocessor-0 interrupt/exception unit: consumer end of device IRQ lines (timer IRQ_O etc.).

---
 rtl/cp0_defs.sv | 33 +++
 rtl/cp0_exc_unit_if.sv | 32 +++
 rtl/cp0_exc_unit.sv | 97 +++++++++
 tb/tb_cp0_exc_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// CP0 shared definitions: register numbers, field positions,
// exception codes and default vector/ID values.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LSB   = 10;
  localparam int IM_MSB   = 15;
  localparam int CAUSE_BD = 31;
  localparam int EXC_LSB  = 2;
  localparam int EXC_MSB  = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_DEFAULT    = 32'h0000_4D49;
  localparam logic [31:0] HANDLER_DEFAULT = 32'h0000_4180;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bundle: mfc0/mtc0 access, M-stage
// exception info, device IRQ lines and entry/return outputs.
interface cp0_exc_unit_if;
  logic [4:0]  rd_addr_i;
  logic [4:0]  wr_addr_i;
  logic        we_i;
  logic [31:0] din_i;
  logic [31:0] pc_i;
  logic        bd_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [5:0]  hwint_i;
  logic        req_o;
  logic [31:0] handler_o;
  logic [31:0] epc_o;
  logic [31:0] dout_o;

  modport master (
    output rd_addr_i, wr_addr_i, we_i, din_i,
    output pc_i, bd_i, exc_valid_i, exc_code_i,
    output eret_i, hwint_i,
    input  req_o, handler_o, epc_o, dout_o
  );

  modport slave (
    input  rd_addr_i, wr_addr_i, we_i, din_i,
    input  pc_i, bd_i, exc_valid_i, exc_code_i,
    input  eret_i, hwint_i,
    output req_o, handler_o, epc_o, dout_o
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 interrupt/exception unit: SR/Cause/EPC/PRId, request
// decision beside the M stage, EXL entry and eret return.
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID    = PRID_DEFAULT,
  parameter logic [31:0] HANDLER = HANDLER_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_unit_if.slave bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] entry_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] dout;
  logic        epc_wr;

  assign int_req = (|(bus.hwint_i & sr_im))
                 & sr_ie & ~sr_exl;
  assign exc_req = bus.exc_valid_i & ~sr_exl;
  assign req     = int_req | exc_req;

  // EPC points at the branch when the faulting op is in its delay slot
  assign entry_pc = bus.bd_i ? bus.pc_i - 32'd4
                             : bus.pc_i;

  assign epc_wr = bus.we_i & (bus.wr_addr_i == REG_EPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hwint_i;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? EXC_INT
                             : bus.exc_code_i;
        cause_bd  <= bus.bd_i;
        epc       <= word_align(entry_pc);
      end else begin
        if (bus.we_i && bus.wr_addr_i == REG_SR) begin
          sr_im  <= bus.din_i[IM_MSB:IM_LSB];
          sr_exl <= bus.din_i[SR_EXL];
          sr_ie  <= bus.din_i[SR_IE];
        end
        if (epc_wr)
          epc <= word_align(bus.din_i);
        // eret overrides a same-cycle mtc0 of EXL
        if (bus.eret_i)
          sr_exl <= 1'b0;
      end
    end
  end

  assign sr_word = {16'b0, sr_im, 8'b0,
                    sr_exl, sr_ie};

  assign cause_word = {cause_bd, 15'b0, cause_ip,
                       3'b0, cause_exc, 2'b0};

  always_comb begin
    dout = '0;
    case (bus.rd_addr_i)
      REG_SR:    dout = sr_word;
      REG_CAUSE: dout = cause_word;
      REG_EPC:   dout = epc;
      REG_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

  assign bus.req_o     = req;
  assign bus.handler_o = HANDLER;
  assign bus.dout_o    = dout;
  assign bus.epc_o     = epc_wr ? word_align(bus.din_i)
                                : epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: word-level model
// compared every cycle plus directed literal checks.
module tb_cp0_exc_unit;
  import cp0_defs::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  cp0_exc_unit_if bus ();

  cp0_exc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state as architectural 32-bit register images
  logic [31:0] m_sr    = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc   = '0;

  function automatic bit m_irq();
    logic [31:0] pend;
    pend = {16'b0, bus.hwint_i, 10'b0} & m_sr & 32'h0000_FC00;
    return (pend != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_irq() || (bus.exc_valid_i && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout();
    case (bus.rd_addr_i)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4D49;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_o();
    if (bus.we_i && bus.wr_addr_i == 5'd14)
      return bus.din_i & 32'hFFFF_FFFC;
    return m_epc;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] pc;
    logic [4:0]  code;
    bit          take;
    bit          irq;
    take = m_req();
    irq  = m_irq();
    if (reset) begin
      m_sr = '0;
      m_cause = '0;
      m_epc = '0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00)
              | ({26'b0, bus.hwint_i} << 10);
      if (take) begin
        m_sr = m_sr | 32'h2;
        code = irq ? 5'd0 : bus.exc_code_i;
        m_cause = (m_cause & 32'h7FFF_FF83)
                | ({31'b0, bus.bd_i} << 31)
                | ({27'b0, code} << 2);
        pc = bus.bd_i ? bus.pc_i - 32'd4 : bus.pc_i;
        m_epc = pc & 32'hFFFF_FFFC;
      end else begin
        if (bus.we_i && bus.wr_addr_i == 5'd12)
          m_sr = bus.din_i & 32'h0000_FC03;
        if (bus.we_i && bus.wr_addr_i == 5'd14)
          m_epc = bus.din_i & 32'hFFFF_FFFC;
        if (bus.eret_i)
          m_sr = m_sr & ~32'h2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_o", {31'b0, bus.req_o}, {31'b0, m_req()});
      check("epc_o", bus.epc_o, m_epc_o());
      check("dout_o", bus.dout_o, m_dout());
      check("handler_o", bus.handler_o, 32'h0000_4180);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm,
                        input logic [4:0] a,
                        input logic [31:0] exp);
    bus.rd_addr_i = a;
    #1;
    check(nm, bus.dout_o, exp);
  endtask

  task automatic req_chk(input string nm, input bit exp);
    #1;
    check(nm, {31'b0, bus.req_o}, {31'b0, exp});
  endtask

  task automatic mtc0(input logic [4:0] a,
                      input logic [31:0] d);
    bus.we_i = 1'b1;
    bus.wr_addr_i = a;
    bus.din_i = d;
    step();
    bus.we_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.rd_addr_i = '0;
    bus.wr_addr_i = '0;
    bus.we_i = 1'b0;
    bus.din_i = '0;
    bus.pc_i = '0;
    bus.bd_i = 1'b0;
    bus.exc_valid_i = 1'b0;
    bus.exc_code_i = '0;
    bus.eret_i = 1'b0;
    bus.hwint_i = '0;
    step();
    step();
    chk_en = 1'b1;
    req_chk("reset_req", 1'b0);
    rd_chk("reset_dout0", 5'd0, 32'h0);
    check("reset_epc_o", bus.epc_o, 32'h0);
    rd_chk("reset_sr", REG_SR, 32'h0);
    step();
    reset = 1'b0;
    rd_chk("prid", REG_PRID, 32'h0000_4D49);
    rd_chk("unmapped", 5'd7, 32'h0);

    // 1: enabled timer interrupt
    mtc0(REG_SR, 32'h0000_0401);
    bus.hwint_i = 6'b000001;
    bus.pc_i = 32'h3010;
    req_chk("t1_req", 1'b1);
    step();
    rd_chk("t1_epc", REG_EPC, 32'h3010);
    rd_chk("t1_cause", REG_CAUSE, 32'h0000_0400);
    rd_chk("t1_sr", REG_SR, 32'h0000_0403);
    bus.hwint_i = '0;
    bus.eret_i = 1'b1;
    step();
    bus.eret_i = 1'b0;

    // 2: overflow in a delay slot with interrupts disabled
    mtc0(REG_SR, 32'h0000_0400);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i = EXC_OV;
    bus.bd_i = 1'b1;
    bus.pc_i = 32'h3024;
    req_chk("t2_req", 1'b1);
    step();
    bus.exc_valid_i = 1'b0;
    bus.bd_i = 1'b0;
    rd_chk("t2_epc", REG_EPC, 32'h3020);
    rd_chk("t2_cause", REG_CAUSE, 32'h8000_0030);
    rd_chk("t2_sr", REG_SR, 32'h0000_0402);
    bus.eret_i = 1'b1;
    step();
    bus.eret_i = 1'b0;

    // 3: interrupt and RI together -> interrupt wins
    mtc0(REG_SR, 32'h0000_0401);
    bus.hwint_i = 6'b000001;
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i = EXC_RI;
    bus.pc_i = 32'h3050;
    req_chk("t3_req", 1'b1);
    step();
    rd_chk("t3_cause", REG_CAUSE, 32'h0000_0400);
    rd_chk("t3_epc", REG_EPC, 32'h3050);

    // 4: EXL blocks nested entry
    bus.exc_code_i = EXC_ADEL;
    bus.pc_i = 32'h3060;
    req_chk("t4_req", 1'b0);
    step();
    bus.exc_valid_i = 1'b0;
    rd_chk("t4_epc", REG_EPC, 32'h3050);
    rd_chk("t4_cause", REG_CAUSE, 32'h0000_0400);

    // 5: mtc0 EPC with eret in one cycle
    bus.hwint_i = '0;
    bus.we_i = 1'b1;
    bus.wr_addr_i = REG_EPC;
    bus.din_i = 32'h3043;
    bus.eret_i = 1'b1;
    #1;
    check("t5_epc_o", bus.epc_o, 32'h3040);
    step();
    bus.we_i = 1'b0;
    bus.eret_i = 1'b0;
    rd_chk("t5_sr", REG_SR, 32'h0000_0401);
    rd_chk("t5_epc", REG_EPC, 32'h3040);

    // Cause is read-only to mtc0
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    rd_chk("cause_ro", REG_CAUSE, 32'h0);

    // 6: reset while in a handler
    mtc0(REG_SR, 32'h0000_FC03);
    bus.hwint_i = 6'h3F;
    req_chk("t6_req_exl", 1'b0);
    reset = 1'b1;
    step();
    rd_chk("t6_sr", REG_SR, 32'h0);
    rd_chk("t6_cause", REG_CAUSE, 32'h0);
    rd_chk("t6_epc", REG_EPC, 32'h0);
    reset = 1'b0;
    step();
    rd_chk("t6_ip", REG_CAUSE, 32'h0000_FC00);
    req_chk("t6_req", 1'b0);

    // 7: delay-slot EPC wraps below zero
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i = EXC_ADES;
    bus.bd_i = 1'b1;
    bus.pc_i = 32'h0000_0002;
    step();
    bus.exc_valid_i = 1'b0;
    bus.bd_i = 1'b0;
    rd_chk("t7_epc", REG_EPC, 32'hFFFF_FFFC);
    rd_chk("t7_cause", REG_CAUSE, 32'h8000_FC14);
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
